// File: rtl/dmem_mmio.sv
// Data-side memory stage: byte-writable word RAM plus an MMIO window holding a console TX FIFO
// and a cycle counter. Define CYCLE_CNT_EN to build the counter; otherwise CYCLE reads 0.
module dmem_mmio #(
  parameter int unsigned AW         = 10,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] drdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned PW    = $clog2(FIFO_DEPTH);
  localparam int unsigned DEPTH = 2 ** AW;

  logic [31:0]   mem [DEPTH];
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW:0]   wptr, rptr, count;
  logic          overflow;
  logic [31:0]   cycle_cnt;
  logic          is_mmio, wr_any, ram_we;
  logic          push_req, push_ok, pop, ovf_set, ovf_clr;
  logic          empty, full;
  logic [AW-1:0] idx;
  logic [1:0]    ofs;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^daddr[1:0];

  // Address decode
  assign is_mmio = (daddr[31:4] == MMIO_BASE[31:4]);
  assign idx     = daddr[AW+1:2];
  assign ofs     = daddr[3:2];
  assign wr_any  = |dwe;
  assign ram_we  = !is_mmio && wr_any;

  // FIFO status and handshake; a pop frees the slot for a same-cycle push when full
  assign count    = wptr - rptr;
  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(FIFO_DEPTH));
  assign tx_valid = !empty;
  assign pop      = tx_valid && tx_ready;
  assign push_req = is_mmio && (ofs == 2'd0) && dwe[0];
  assign push_ok  = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ovf_clr  = is_mmio && (ofs == 2'd1) && wr_any;
  assign tx_data  = empty ? 8'h00 : fifo_mem[rptr[PW-1:0]];

  // RAM lanes; contents survive reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we && dwe[i]) mem[idx][8*i +: 8] <= dwdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !reset) fifo_mem[wptr[PW-1:0]] <= dwdata[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + (PW+1)'(1);
      if (pop)     rptr <= rptr + (PW+1)'(1);
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

`ifdef CYCLE_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cycle_cnt <= '0;
    else       cycle_cnt <= cycle_cnt + 32'd1;
  end
`else
  assign cycle_cnt = '0;
`endif

  // Combinational read mux
  always_comb begin
    drdata = mem[idx];
    if (is_mmio) begin
      case (ofs)
        2'd1:    drdata = {overflow, 23'b0, 4'(count), 2'b00, full, empty};
        2'd2:    drdata = cycle_cnt;
        default: drdata = 32'h0;
      endcase
    end
  end

endmodule
